// File: rtl/uart_rx_controller_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_controller_if                                         |
// | Purpose  : Groups the controller's strobe, status and consumer           |
// |            handshake signals.                                            |
// |            master : the receive sequencer (drives strobes and flags)     |
// |            slave  : shift register / consumer side (drives rx_ack_i)     |
// | Signals  : rxd_sync_o  synchronised serial line                          |
// |            midbit      bit-centre strobe                                 |
// |            shift_en    load command at a valid stop-bit centre           |
// |            rx_valid_o  byte available, held until acked                  |
// |            frame_err_o sticky framing error                              |
// |            overrun_o   sticky overrun                                    |
// |            busy_o      sequencer not idle                                |
// |            rx_ack_i    consumer acknowledge                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface uart_rx_controller_if;
   logic rxd_sync_o;
   logic midbit;
   logic shift_en;
   logic rx_valid_o;
   logic frame_err_o;
   logic overrun_o;
   logic busy_o;
   logic rx_ack_i;

   modport master (
      output rxd_sync_o, midbit, shift_en, rx_valid_o,
             frame_err_o, overrun_o, busy_o,
      input  rx_ack_i
   );

   modport slave (
      input  rxd_sync_o, midbit, shift_en, rx_valid_o,
             frame_err_o, overrun_o, busy_o,
      output rx_ack_i
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_controller.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_controller                                            |
// | Purpose  : UART receive sequencer. Synchronises RxD, qualifies the start |
// |            bit at its midpoint, counts 16x oversample ticks and issues   |
// |            midbit / shift_en strobes for an external 8-bit shift         |
// |            register, plus valid/ack handshake and error flags.           |
// | Ports    : clk_i    system clock                                         |
// |            rstb_i   asynchronous active-low reset                        |
// |            baudx16  single-cycle 16x baud tick                           |
// |            RxD      raw serial line (idle high)                          |
// |            bus      strobes, flags and ack (master modport)              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_rx_controller #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int MID_SAMPLE = 7
) (
   input  wire logic             clk_i,
   input  wire logic             rstb_i,
   input  wire logic             baudx16,
   input  wire logic             RxD,
   uart_rx_controller_if.master  bus
);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_START = 2'd1;
   localparam logic [1:0] c_ST_DATA  = 2'd2;
   localparam logic [1:0] c_ST_STOP  = 2'd3;

   localparam logic [3:0] c_MID_CNT  = MID_SAMPLE[3:0];
   localparam logic [3:0] c_LAST_CNT = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] c_LAST_BIT = 4'(DATA_BITS);

   logic       r_sync1;
   logic       r_sync2;
   logic [1:0] r_state;
   logic [3:0] r_sample_cnt;
   logic [3:0] r_bit_cnt;
   logic       r_rx_valid;
   logic       r_frame_err;
   logic       r_overrun;

   logic [1:0] w_state_nxt;
   logic [3:0] w_sample_nxt;
   logic [3:0] w_bit_nxt;
   logic       w_midbit;
   logic       w_shift_en;
   logic       w_stop_bad;
   logic       w_busy;

   // Two-flop synchroniser; reset to the idle (mark) level so that reset
   // release never looks like a start edge.
   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= RxD;
         r_sync2 <= r_sync1;
      end
   end

   // State and counter register
   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) begin
         r_state      <= c_ST_IDLE;
         r_sample_cnt <= 4'd0;
         r_bit_cnt    <= 4'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_sample_cnt <= w_sample_nxt;
         r_bit_cnt    <= w_bit_nxt;
      end
   end

   // Next-state logic; everything holds between ticks.
   always_comb begin
      w_state_nxt  = r_state;
      w_sample_nxt = r_sample_cnt;
      w_bit_nxt    = r_bit_cnt;
      if (baudx16) begin
         case (r_state)
            c_ST_IDLE: begin
               if (!r_sync2) begin
                  w_state_nxt  = c_ST_START;
                  w_sample_nxt = 4'd0;
               end
            end
            c_ST_START: begin
               if (r_sample_cnt == c_MID_CNT) begin
                  w_sample_nxt = 4'd0;
                  if (r_sync2) begin
                     // Line back high at the midpoint: noise, not a start bit
                     w_state_nxt = c_ST_IDLE;
                  end else begin
                     w_state_nxt = c_ST_DATA;
                     w_bit_nxt   = 4'd0;
                  end
               end else begin
                  w_sample_nxt = r_sample_cnt + 4'd1;
               end
            end
            c_ST_DATA: begin
               if (r_sample_cnt == c_LAST_CNT) begin
                  w_sample_nxt = 4'd0;
                  w_bit_nxt    = r_bit_cnt + 4'd1;
                  if (r_bit_cnt + 4'd1 == c_LAST_BIT) begin
                     w_state_nxt = c_ST_STOP;
                  end
               end else begin
                  w_sample_nxt = r_sample_cnt + 4'd1;
               end
            end
            c_ST_STOP: begin
               if (r_sample_cnt == c_LAST_CNT) begin
                  w_sample_nxt = 4'd0;
                  w_state_nxt  = c_ST_IDLE;
               end else begin
                  w_sample_nxt = r_sample_cnt + 4'd1;
               end
            end
            default: begin
               w_state_nxt  = c_ST_IDLE;
               w_sample_nxt = 4'd0;
               w_bit_nxt    = 4'd0;
            end
         endcase
      end
   end

   // Output decode (strobes are combinational on the tick cycle)
   always_comb begin
      w_midbit   = baudx16 && (r_sample_cnt == c_LAST_CNT) &&
                   ((r_state == c_ST_DATA) || (r_state == c_ST_STOP));
      w_shift_en = w_midbit && (r_state == c_ST_STOP) && r_sync2;
      w_stop_bad = w_midbit && (r_state == c_ST_STOP) && !r_sync2;
      w_busy     = (r_state != c_ST_IDLE);
   end

   // Consumer flags. A load in the same cycle as an ack wins for rx_valid;
   // overrun is only raised when the previous byte was not being acked.
   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) begin
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_shift_en) begin
            r_rx_valid <= 1'b1;
         end else if (bus.rx_ack_i) begin
            r_rx_valid <= 1'b0;
         end

         if (w_shift_en && r_rx_valid && !bus.rx_ack_i) begin
            r_overrun <= 1'b1;
         end else if (bus.rx_ack_i) begin
            r_overrun <= 1'b0;
         end

         if (w_stop_bad) begin
            r_frame_err <= 1'b1;
         end else if (bus.rx_ack_i) begin
            r_frame_err <= 1'b0;
         end
      end
   end

   assign bus.rxd_sync_o  = r_sync2;
   assign bus.midbit      = w_midbit;
   assign bus.shift_en    = w_shift_en;
   assign bus.rx_valid_o  = r_rx_valid;
   assign bus.frame_err_o = r_frame_err;
   assign bus.overrun_o   = r_overrun;
   assign bus.busy_o      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_controller.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx_controller                                         |
// | Purpose  : Self-checking bench for uart_rx_controller. Models the        |
// |            external shift register, drives serial frames and compares    |
// |            flags/data against a frame-level reference model.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_rx_controller;

   logic clk     = 1'b0;
   logic rstb_i  = 1'b0;
   logic baudx16 = 1'b0;
   logic RxD     = 1'b1;

   uart_rx_controller_if u_if ();

   uart_rx_controller #(
      .DATA_BITS  (8),
      .OVERSAMPLE (16),
      .MID_SAMPLE (7)
   ) dut (
      .clk_i   (clk),
      .rstb_i  (rstb_i),
      .baudx16 (baudx16),
      .RxD     (RxD),
      .bus     (u_if)
   );

   always #5 clk = ~clk;

   // 16x tick every 4 clocks -> 64 clocks per bit
   initial begin
      int k;
      k = 0;
      forever begin
         @(negedge clk);
         baudx16 = (k == 3);
         k = (k + 1) % 4;
      end
   end

   // External shift register + event recorder
   int          cyc;
   int          n_shift;
   int          n_load;
   int          mid_t[$];
   logic [7:0]  sr;
   logic [7:0]  shreg_data;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (u_if.midbit) mid_t.push_back(cyc);
      if (u_if.midbit && !u_if.shift_en) begin
         n_shift <= n_shift + 1;
         sr      <= {u_if.rxd_sync_o, sr[7:1]};
      end
      if (u_if.shift_en) begin
         n_load     <= n_load + 1;
         shreg_data <= sr;
      end
   end

   typedef struct {
      logic [7:0] data;
      bit         stop;
      bit         ack_first;
      bit         e_valid;
      bit         e_ferr;
      bit         e_ovr;
      logic [7:0] e_data;
   } vec_t;

   vec_t vec[8];
   int   checks;
   int   failures;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop);
      RxD = 1'b0;
      repeat (64) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RxD = d[i];
         repeat (64) @(negedge clk);
      end
      RxD = stop;
      repeat (64) @(negedge clk);
      RxD = 1'b1;
   endtask

   task automatic pulse_ack;
      @(negedge clk);
      u_if.rx_ack_i = 1'b1;
      @(negedge clk);
      u_if.rx_ack_i = 1'b0;
      #1;
      chk("ack_clears_flags", {29'd0, u_if.rx_valid_o, u_if.frame_err_o, u_if.overrun_o}, 32'd0);
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (u_if.busy_o && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_idle_timeout"}, 32'(n >= 2000), 32'd0);
   endtask

   // Watches for the load strobe; optionally acks in exactly that cycle.
   task automatic watch_se(input bit do_ack, output bit seen, output bit v_at, output bit v_after);
      bit s;
      s = 1'b0;
      v_at = 1'b0;
      v_after = 1'b0;
      for (int n = 0; n < 800 && !s; n++) begin
         @(negedge clk);
         #1;
         if (u_if.shift_en) begin
            s = 1'b1;
            v_at = u_if.rx_valid_o;
            if (do_ack) u_if.rx_ack_i = 1'b1;
            @(negedge clk);
            u_if.rx_ack_i = 1'b0;
            #1;
            v_after = u_if.rx_valid_o;
         end
      end
      seen = s;
   endtask

   task automatic run_vec(input string tag, input vec_t v, input bit prior_valid);
      int  s0, l0, q0, bad;
      bit  seen, v_at, v_after;
      if (v.ack_first) pulse_ack();
      s0 = n_shift;
      l0 = n_load;
      q0 = mid_t.size();
      fork
         send_frame(v.data, v.stop);
         watch_se(1'b0, seen, v_at, v_after);
      join
      wait_idle(tag);
      @(negedge clk);
      #1;
      chk({tag, "_midbits"},   32'(mid_t.size() - q0), 32'd9);
      chk({tag, "_shifts"},    32'(n_shift - s0), v.stop ? 32'd8 : 32'd9);
      chk({tag, "_loads"},     32'(n_load - l0), {31'd0, v.stop});
      chk({tag, "_load_seen"}, {31'd0, seen}, {31'd0, v.stop});
      if (v.stop) begin
         chk({tag, "_valid_before_load"}, {31'd0, v_at}, {31'd0, prior_valid});
         chk({tag, "_valid_after_load"},  {31'd0, v_after}, 32'd1);
      end
      bad = 0;
      if (mid_t.size() - q0 == 9) begin
         for (int i = 0; i < 8; i++) begin
            if (mid_t[q0 + i + 1] - mid_t[q0 + i] != 64) bad++;
         end
      end
      chk({tag, "_midbit_gap"}, 32'(bad), 32'd0);
      chk({tag, "_valid"}, {31'd0, u_if.rx_valid_o},  {31'd0, v.e_valid});
      chk({tag, "_ferr"},  {31'd0, u_if.frame_err_o}, {31'd0, v.e_ferr});
      chk({tag, "_ovr"},   {31'd0, u_if.overrun_o},   {31'd0, v.e_ovr});
      chk({tag, "_data"},  {24'd0, shreg_data},       {24'd0, v.e_data});
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit         seen, v_at, v_after, prior, m_valid, m_ferr, m_ovr;
      logic [7:0] m_data;
      int         s0, l0, q0;
      vec_t       v;

      u_if.rx_ack_i = 1'b0;
      checks   = 0;
      failures = 0;

      //            data   stop ackf  val ferr ovr  data
      vec[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
      vec[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
      vec[2] = '{8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11};
      vec[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22};
      vec[4] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A};
      vec[5] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
      vec[6] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
      vec[7] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};

      // Reset: line held low must not leak through the synchroniser
      RxD = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk("reset_outputs", {25'd0, u_if.rxd_sync_o, u_if.busy_o, u_if.midbit, u_if.shift_en,
                            u_if.rx_valid_o, u_if.frame_err_o, u_if.overrun_o}, 32'h40);
      @(negedge clk);
      RxD = 1'b1;
      repeat (3) @(negedge clk);
      rstb_i = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      chk("post_reset_idle", {30'd0, u_if.busy_o, u_if.rx_valid_o}, 32'd0);

      // Table-driven frames
      prior = 1'b0;
      for (int i = 0; i < 8; i++) begin
         run_vec($sformatf("vec%0d", i), vec[i], vec[i].ack_first ? 1'b0 : prior);
         prior = vec[i].e_valid;
      end

      // Short low glitch: false start, no strobes, no flags
      pulse_ack();
      s0 = n_shift; l0 = n_load; q0 = mid_t.size();
      @(negedge clk);
      RxD = 1'b0;
      repeat (16) @(negedge clk);
      RxD = 1'b1;
      #1;
      chk("glitch_busy", {31'd0, u_if.busy_o}, 32'd1);
      wait_idle("glitch");
      repeat (100) @(negedge clk);
      #1;
      chk("glitch_midbits", 32'(mid_t.size() - q0), 32'd0);
      chk("glitch_loads",   32'(n_load - l0), 32'd0);
      chk("glitch_flags",   {28'd0, u_if.busy_o, u_if.rx_valid_o, u_if.frame_err_o, u_if.overrun_o}, 32'd0);

      // Back-to-back frames without ack -> overrun
      l0 = n_load; s0 = n_shift;
      @(negedge clk);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      wait_idle("b2b");
      @(negedge clk);
      #1;
      chk("b2b_loads",  32'(n_load - l0), 32'd2);
      chk("b2b_shifts", 32'(n_shift - s0), 32'd16);
      chk("b2b_flags",  {29'd0, u_if.rx_valid_o, u_if.frame_err_o, u_if.overrun_o}, 32'b101);
      chk("b2b_data",   {24'd0, shreg_data}, 32'h22);
      pulse_ack();

      // Ack coincident with the load of a second frame
      @(negedge clk);
      send_frame(8'h33, 1'b1);
      wait_idle("coinc_a");
      fork
         send_frame(8'h44, 1'b1);
         watch_se(1'b1, seen, v_at, v_after);
      join
      wait_idle("coinc_b");
      @(negedge clk);
      #1;
      chk("coinc_seen",  {31'd0, seen}, 32'd1);
      chk("coinc_flags", {29'd0, u_if.rx_valid_o, u_if.frame_err_o, u_if.overrun_o}, 32'b100);
      chk("coinc_data",  {24'd0, shreg_data}, 32'h44);
      pulse_ack();

      // Reset during data bit 4 of 0xFF
      l0 = n_load;
      @(negedge clk);
      RxD = 1'b0;
      repeat (64) @(negedge clk);
      RxD = 1'b1;
      repeat (64 * 4 + 32) @(negedge clk);
      #1;
      chk("midreset_busy_before", {31'd0, u_if.busy_o}, 32'd1);
      #2;
      rstb_i = 1'b0;
      #1;
      chk("midreset_outputs", {25'd0, u_if.rxd_sync_o, u_if.busy_o, u_if.midbit, u_if.shift_en,
                               u_if.rx_valid_o, u_if.frame_err_o, u_if.overrun_o}, 32'h40);
      repeat (4) @(negedge clk);
      rstb_i = 1'b1;
      repeat (400) @(negedge clk);
      #1;
      chk("midreset_no_load", 32'(n_load - l0), 32'd0);
      chk("midreset_quiet", {28'd0, u_if.busy_o, u_if.rx_valid_o, u_if.frame_err_o, u_if.overrun_o}, 32'd0);
      v = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A};
      run_vec("after_reset", v, 1'b0);

      // Randomised frames against a frame-level model
      pulse_ack();
      m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_data = 8'h5A;
      for (int i = 0; i < 12; i++) begin
         v.data      = 8'($urandom);
         v.stop      = ($urandom_range(0, 3) != 0);
         v.ack_first = 1'($urandom_range(0, 1));
         if (v.ack_first) begin
            m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
         end
         prior = m_valid;
         if (v.stop) begin
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_data  = v.data;
         end else begin
            m_ferr = 1'b1;
         end
         v.e_valid = m_valid;
         v.e_ferr  = m_ferr;
         v.e_ovr   = m_ovr;
         v.e_data  = m_data;
         @(negedge clk);
         run_vec($sformatf("rnd%0d", i), v, prior);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
